// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with frame-aligned double buffering
// and a per-digit anode-off guard interval. Optional leading-zero blanking: SSEG_LZ_BLANK_EN.
module sseg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int DP_POS       = 4
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [2:0]    DP_SEL    = 3'(DP_POS);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   pending;
  logic          pending_flag;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nibble;
  logic          blank_digit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 2'd3);
  assign nibble    = shadow[4*idx +: 4];

`ifdef SSEG_LZ_BLANK_EN
  always_comb begin
    blank_digit = 1'b0;
    case (idx)
      2'd1:    blank_digit = (shadow[15:4]  == 12'h000);
      2'd2:    blank_digit = (shadow[15:8]  == 8'h00);
      2'd3:    blank_digit = (shadow[15:12] == 4'h0);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  // Pin values for the current counter/index; registered below for one cycle of latency.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (cnt >= BLANK_END) begin
      dp_d = ({1'b0, idx} != DP_SEL);
      if (!blank_digit) begin
        an_d  = ~(4'b0001 << idx);
        seg_d = hex_to_seg(nibble);
      end
    end
  end

  // din_valid is a fire-and-forget strobe (no ready): every strobe is accepted, the
  // newest word before a frame boundary is the one that reaches the display.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= 2'd0;
      shadow       <= 16'h0000;
      pending      <= 16'h0000;
      pending_flag <= 1'b0;
      frame_start  <= 1'b0;
      an           <= 4'hF;
      seg          <= 7'h7F;
      dp           <= 1'b1;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      if (frame_end) begin
        if (din_valid) begin
          shadow <= din;
        end else if (pending_flag) begin
          shadow <= pending;
        end
        pending_flag <= 1'b0;
      end else if (din_valid) begin
        pending      <= din;
        pending_flag <= 1'b1;
      end
      frame_start <= frame_end;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

endmodule
